// File: rtl/eau_pkg.sv
// Shared sizing and types for the element alignment unit collector.
// Chunk vectors are packed so whole vectors compare and move as one value.
package eau_pkg;
  localparam int VLEN = 256;
  localparam int BSW  = 5;
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam int CW   = BSW + 2;
  localparam int NW   = BSW + 1;
  localparam int NS   = 2 * BS;

  localparam logic [CW-1:0] BS_CW = CW'(BS);
  localparam logic [NW-1:0] BS_NW = NW'(BS);

  typedef logic [BLEN-1:0] chunk_t;
  typedef chunk_t [BS-1:0] vec_t;
  typedef chunk_t [NS-1:0] slots_t;

  // Chunk counts above BS are treated as a full vector.
  function automatic logic [NW-1:0] sat_num(input logic [NW-1:0] n);
    return (n > BS_NW) ? BS_NW : n;
  endfunction
endpackage

// File: rtl/eau_collect_buf.sv
// One stream's 2*BS-slot buffer: drop `pop` oldest chunks, append `push` new ones.
// Slot 0 always holds the oldest chunk; slots at or beyond the occupancy stay zero.
module eau_collect_buf
  import eau_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] pop,
  input  logic [CW-1:0] push,
  input  vec_t          data,
  output vec_t          head
);
  slots_t        slot_q, slot_d;
  logic [CW-1:0] keep;

  assign keep = count - pop;

  // Survivors shift down by pop; new lanes land right after the survivors.
  always_comb begin
    slot_d = '0;
    for (int j = 0; j < NS; j++) begin
      if (CW'(j) < keep)
        slot_d[j] = slot_q[NW'(j) + pop[NW-1:0]];
      else if ((CW'(j) - keep) < push)
        slot_d[j] = data[BSW'(CW'(j) - keep)];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign head = slot_q[BS-1:0];
endmodule

// File: rtl/eau_collect.sv
// Repacks partial aligned chunk beats from the eau into dense BS-chunk vectors
// for both operand streams, draining the residue as an out_last vector on stream end.
module eau_collect
  import eau_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_num,
  input  logic          in_last,
  input  vec_t          in_data1,
  input  vec_t          in_data2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_num,
  output logic          out_last,
  output vec_t          out_data1,
  output vec_t          out_data2
);
  logic [CW-1:0] count_q, count_d;
  logic          flush_q, flush_d;
  logic [CW-1:0] pop, push;
  logic          acc, fire;
  vec_t          head1, head2;

  // in_ready looks only at registered state so upstream sees no comb path.
  assign in_ready  = !flush_q && (count_q <= BS_CW);
  assign acc       = in_valid && in_ready;
  assign out_valid = (count_q >= BS_CW) || flush_q;
  assign out_last  = flush_q && (count_q <= BS_CW);
  assign fire      = out_valid && out_ready;

  always_comb begin
    out_num = '0;
    if (out_valid)
      out_num = (flush_q && (count_q < BS_CW)) ? count_q[NW-1:0] : BS_NW;
  end

  always_comb begin
    push    = acc ? CW'(sat_num(in_num)) : '0;
    pop     = fire ? CW'(out_num) : '0;
    count_d = count_q - pop + push;
    flush_d = flush_q;
    if (acc && in_last)        flush_d = 1'b1;
    else if (fire && out_last) flush_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  eau_collect_buf u_buf1 (
    .clk   (clk),
    .rstn  (rstn),
    .count (count_q),
    .pop   (pop),
    .push  (push),
    .data  (in_data1),
    .head  (head1)
  );

  eau_collect_buf u_buf2 (
    .clk   (clk),
    .rstn  (rstn),
    .count (count_q),
    .pop   (pop),
    .push  (push),
    .data  (in_data2),
    .head  (head2)
  );

  always_comb begin
    out_data1 = '0;
    out_data2 = '0;
    for (int i = 0; i < BS; i++) begin
      if (NW'(i) < out_num) begin
        out_data1[i] = head1[i];
        out_data2[i] = head2[i];
      end
    end
  end
endmodule

// File: tb/tb_eau_collect.sv
// Randomized bench for eau_collect against a chunk-queue model of the stream.
module tb_eau_collect;
  import eau_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready, in_last;
  logic [NW-1:0] in_num;
  vec_t          in_data1, in_data2;
  logic          out_valid, out_ready, out_last;
  logic [NW-1:0] out_num;
  vec_t          out_data1, out_data2;

  int total = 0;
  int bad   = 0;

  chunk_t q1[$];
  chunk_t q2[$];
  bit     mflush;
  bit     last_acc;

  always #5 clk = ~clk;

  eau_collect dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_last   (in_last),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_last  (out_last),
    .out_data1 (out_data1),
    .out_data2 (out_data2)
  );

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !mflush && (q1.size() <= BS);
  endfunction

  function automatic bit m_valid();
    return (q1.size() >= BS) || mflush;
  endfunction

  function automatic int m_num();
    if (!m_valid()) return 0;
    if (mflush && q1.size() < BS) return q1.size();
    return BS;
  endfunction

  task automatic check_out();
    vec_t e1, e2;
    int   n;
    n  = m_num();
    e1 = '0;
    e2 = '0;
    for (int i = 0; i < n; i++) begin
      e1[i] = q1[i];
      e2[i] = q2[i];
    end
    chk("in_ready",  VLEN'(in_ready),  VLEN'(m_ready()));
    chk("out_valid", VLEN'(out_valid), VLEN'(m_valid()));
    chk("out_num",   VLEN'(out_num),   VLEN'(n));
    chk("out_last",  VLEN'(out_last),  VLEN'(mflush && q1.size() <= BS));
    chk("out_data1", out_data1, e1);
    chk("out_data2", out_data2, e2);
  endtask

  // Called at a falling edge: check state, drive one cycle, advance the model.
  task automatic step(input bit v, input int n, input bit l, input bit r);
    vec_t d1, d2;
    bit   acc, fire, lst;
    int   pn, ns;
    check_out();
    for (int i = 0; i < BS; i++) begin
      d1[i] = chunk_t'($urandom);
      d2[i] = chunk_t'($urandom);
    end
    in_valid  = v;
    in_num    = NW'(n);
    in_last   = l;
    in_data1  = d1;
    in_data2  = d2;
    out_ready = r;
    acc  = v && m_ready();
    fire = m_valid() && r;
    lst  = mflush && q1.size() <= BS;
    pn   = fire ? m_num() : 0;
    ns   = (n > BS) ? BS : n;
    repeat (pn) begin
      void'(q1.pop_front());
      void'(q2.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < ns; i++) begin
        q1.push_back(d1[i]);
        q2.push_back(d2[i]);
      end
      if (l) mflush = 1'b1;
    end else if (fire && lst) begin
      mflush = 1'b0;
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int n, input bit l, input bit r);
    bit done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (m_ready()) begin
        step(1'b1, n, l, r);
        done = last_acc;
      end else begin
        step(1'b0, 0, 1'b0, r);
      end
    end
    chk("send_accept", VLEN'(done), VLEN'(1));
  endtask

  task automatic idle(input int cycles, input bit r);
    repeat (cycles) step(1'b0, 0, 1'b0, r);
  endtask

  task automatic do_reset();
    #2;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_num    = '0;
    out_ready = 1'b0;
    q1.delete();
    q2.delete();
    mflush = 1'b0;
    #1;
    check_out();
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_num    = '0;
    in_data1  = '0;
    in_data2  = '0;
    out_ready = 1'b0;
    mflush    = 1'b0;
    @(negedge clk);
    check_out();
    #2 rstn = 1'b1;
    @(negedge clk);
    idle(2, 1'b1);

    // 20 + 20 chunks: one full vector spanning both beats, 8 left over
    step(1'b1, 20, 1'b0, 1'b1);
    step(1'b1, 20, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("residue8", VLEN'(q1.size()), VLEN'(8));
    step(1'b1, 24, 1'b1, 1'b1);
    idle(3, 1'b1);

    // sustained full beats
    repeat (8) step(1'b1, 32, 1'b0, 1'b1);
    idle(2, 1'b1);

    // stalled consumer: third beat blocked at 48 chunks
    step(1'b1, 32, 1'b0, 1'b0);
    step(1'b1, 16, 1'b0, 1'b0);
    step(1'b1, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    send(16, 1'b0, 1'b1);
    idle(3, 1'b1);

    // flush with residue, and saturated in_num with last
    send(32, 1'b0, 1'b0);
    send(8, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    send(40, 1'b1, 1'b1);
    idle(3, 1'b1);

    // empty flush, then last arriving on the second full vector
    send(0, 1'b1, 1'b1);
    idle(2, 1'b1);
    send(32, 1'b0, 1'b1);
    send(32, 1'b1, 1'b1);
    idle(3, 1'b1);
    send(0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // random traffic with a mid-stream reset
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 40),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
      if (c == 300) do_reset();
    end
    idle(10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
